// File: rtl/bullcow_engine_if.sv
// Entry strobe/code from the switch front end plus score and status toward the display driver.
interface bullcow_engine_if #(
  parameter int NDIG  = 4,
  parameter int DW    = 4,
  parameter int PTS_W = 8
);
  localparam int BW = $clog2(NDIG + 1);

  logic                 enter;
  logic [NDIG*DW-1:0]   code;
  logic                 ready;
  logic [2:0]           state;
  logic                 turn;
  logic                 err;
  logic                 result_valid;
  logic [BW-1:0]        bulls;
  logic [BW-1:0]        cows;
  logic [1:0]           winner;
  logic [PTS_W-1:0]     points_p1;
  logic [PTS_W-1:0]     points_p2;

  modport master (
    output enter, code,
    input  ready, state, turn, err, result_valid, bulls, cows, winner, points_p1, points_p2
  );

  modport slave (
    input  enter, code,
    output ready, state, turn, err, result_valid, bulls, cows, winner, points_p1, points_p2
  );
endinterface

// File: rtl/bullcow_engine.sv
// Two-player Bulls-and-Cows engine; per-player guess limit enabled by BULLCOW_ROUND_LIMIT_EN.
// Result arrives NDIG+1 cycles after an accepted guess; ready is low while scoring and enter is then ignored.
module bullcow_engine #(
  parameter int NDIG        = 4,
  parameter int DW          = 4,
  parameter int DMAX        = 9,
  parameter int PTS_W       = 8,
  parameter int MAX_GUESSES = 10
) (
  input  logic           clock,
  input  logic           reset,
  bullcow_engine_if.slave bus
);
  localparam int CW = NDIG * DW;
  localparam int BW = $clog2(NDIG + 1);
  localparam int IW = $clog2(NDIG);
  localparam logic [DW-1:0] DMAX_D = DW'(DMAX);

  typedef enum logic [2:0] {
    ST_SETUP1 = 3'b000,
    ST_SETUP2 = 3'b001,
    ST_GUESS1 = 3'b010,
    ST_GUESS2 = 3'b011,
    ST_SCORE  = 3'b100,
    ST_END    = 3'b111
  } state_t;

  state_t           st, st_nxt;
  logic [CW-1:0]    secret1, secret2, guess;
  logic [IW-1:0]    idx;
  logic [BW-1:0]    acc_b, acc_c, bulls_q, cows_q;
  logic             turn_q, err_q, rv_q;
  logic [1:0]       winner_q;
  logic [PTS_W-1:0] pts1, pts2;

  function automatic logic code_ok(input logic [CW-1:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (c[i*DW +: DW] > DMAX_D) ok = 1'b0;
      for (int j = i + 1; j < NDIG; j++)
        if (c[i*DW +: DW] == c[j*DW +: DW]) ok = 1'b0;
    end
    return ok;
  endfunction

  logic code_valid;
  assign code_valid = code_ok(bus.code);

  // One guess digit per cycle; P1 (turn 0) is scored against secret2.
  logic [CW-1:0] sec_sel;
  logic [DW-1:0] g_dig;
  logic          hit_b, hit_c, last, win, limit_hit;
  logic [BW-1:0] fin_b, fin_c;

  always_comb begin
    sec_sel = turn_q ? secret1 : secret2;
    g_dig   = guess[int'(idx)*DW +: DW];
    hit_b   = (sec_sel[int'(idx)*DW +: DW] == g_dig);
    hit_c   = 1'b0;
    for (int j = 0; j < NDIG; j++)
      if (j != int'(idx) && sec_sel[j*DW +: DW] == g_dig) hit_c = 1'b1;
    fin_b = acc_b + BW'(hit_b);
    fin_c = acc_c + BW'(hit_c && !hit_b);
    last  = (idx == IW'(NDIG - 1));
    win   = (fin_b == BW'(NDIG));
  end

`ifdef BULLCOW_ROUND_LIMIT_EN
  localparam int GW = $clog2(MAX_GUESSES + 1);
  logic [GW-1:0] gcnt1, gcnt2;

  // P2 always guesses last in a round, so the draw is decided on P2's miss.
  assign limit_hit = turn_q && !win && (gcnt1 == GW'(MAX_GUESSES)) && (gcnt2 == GW'(MAX_GUESSES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gcnt1 <= '0;
      gcnt2 <= '0;
    end else if (st == ST_END && bus.enter) begin
      gcnt1 <= '0;
      gcnt2 <= '0;
    end else if (st == ST_SCORE && last && !win) begin
      if (turn_q) gcnt2 <= gcnt2 + GW'(1);
      else        gcnt1 <= gcnt1 + GW'(1);
    end
  end
`else
  logic unused_max_guesses;
  assign unused_max_guesses = (MAX_GUESSES > 0);
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) st <= ST_SETUP1;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_SETUP1: if (bus.enter && code_valid) st_nxt = ST_SETUP2;
      ST_SETUP2: if (bus.enter && code_valid) st_nxt = ST_GUESS1;
      ST_GUESS1,
      ST_GUESS2: if (bus.enter && code_valid) st_nxt = ST_SCORE;
      ST_SCORE: begin
        if (last) begin
          if (win || limit_hit) st_nxt = ST_END;
          else                  st_nxt = turn_q ? ST_GUESS1 : ST_GUESS2;
        end
      end
      ST_END:    if (bus.enter) st_nxt = ST_SETUP1;
      default:   st_nxt = ST_SETUP1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      secret1  <= '0;
      secret2  <= '0;
      guess    <= '0;
      idx      <= '0;
      acc_b    <= '0;
      acc_c    <= '0;
      bulls_q  <= '0;
      cows_q   <= '0;
      turn_q   <= 1'b0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
      winner_q <= 2'b00;
      pts1     <= '0;
      pts2     <= '0;
    end else begin
      err_q <= 1'b0;
      rv_q  <= 1'b0;
      case (st)
        ST_SETUP1, ST_SETUP2, ST_GUESS1, ST_GUESS2: begin
          if (bus.enter) begin
            if (!code_valid) begin
              err_q <= 1'b1;
            end else if (st == ST_SETUP1) begin
              secret1 <= bus.code;
              turn_q  <= 1'b1;
            end else if (st == ST_SETUP2) begin
              secret2 <= bus.code;
              turn_q  <= 1'b0;
            end else begin
              guess <= bus.code;
              idx   <= '0;
              acc_b <= '0;
              acc_c <= '0;
            end
          end
        end
        ST_SCORE: begin
          if (!last) begin
            idx   <= idx + IW'(1);
            acc_b <= fin_b;
            acc_c <= fin_c;
          end else begin
            bulls_q <= fin_b;
            cows_q  <= fin_c;
            rv_q    <= 1'b1;
            if (win) begin
              winner_q <= turn_q ? 2'b10 : 2'b01;
              if (turn_q) begin
                if (pts2 != '1) pts2 <= pts2 + PTS_W'(1);
              end else begin
                if (pts1 != '1) pts1 <= pts1 + PTS_W'(1);
              end
            end else if (limit_hit) begin
              winner_q <= 2'b11;
            end else begin
              turn_q <= ~turn_q;
            end
          end
        end
        ST_END: begin
          if (bus.enter) begin
            winner_q <= 2'b00;
            turn_q   <= 1'b0;
            secret1  <= '0;
            secret2  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready        = (st != ST_SCORE);
  assign bus.state        = st;
  assign bus.turn         = turn_q;
  assign bus.err          = err_q;
  assign bus.result_valid = rv_q;
  assign bus.bulls        = bulls_q;
  assign bus.cows         = cows_q;
  assign bus.winner       = winner_q;
  assign bus.points_p1    = pts1;
  assign bus.points_p2    = pts2;
endmodule

// File: tb/tb_bullcow_engine.sv
// Bench for bullcow_engine: directed games plus random play against a digit-level reference model.
module tb_bullcow_engine;
  localparam int NDIG  = 4;
  localparam int DW    = 4;
  localparam int DMAX  = 9;
  localparam int PTS_W = 2;
  localparam int MAXG  = 2;
  localparam int CW    = NDIG * DW;
  localparam int NV    = 1 << DW;
  localparam int PMAX  = (1 << PTS_W) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bullcow_engine_if #(.NDIG(NDIG), .DW(DW), .PTS_W(PTS_W)) bus ();

  bullcow_engine #(
    .NDIG(NDIG), .DW(DW), .DMAX(DMAX), .PTS_W(PTS_W), .MAX_GUESSES(MAXG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int kind;   // 0 = err pulse, 1 = scored result
    int at;
    int bulls, cows, winner, p1, p2, st, turn;
  } exp_t;
  exp_t q[$];

  // Reference model state
  int m_st, m_turn, m_win, m_p1, m_p2, busy_until;
  logic [CW-1:0] m_sec1, m_sec2;
`ifdef BULLCOW_ROUND_LIMIT_EN
  int m_gc1, m_gc2;
`endif

  function automatic int dig(logic [CW-1:0] c, int i);
    logic [CW-1:0] t;
    t = c >> (i * DW);
    return int'(t[DW-1:0]);
  endfunction

  function automatic bit m_valid(logic [CW-1:0] c);
    int cnt [NV];
    for (int v = 0; v < NV; v++) cnt[v] = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig(c, i) > DMAX) return 1'b0;
      cnt[dig(c, i)]++;
      if (cnt[dig(c, i)] > 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Cows = digits shared with the secret minus those already in place.
  function automatic void m_score(input logic [CW-1:0] s, input logic [CW-1:0] g, output int b, output int c);
    int common;
    b = 0;
    common = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig(g, i) == dig(s, i)) b++;
      for (int j = 0; j < NDIG; j++)
        if (dig(s, j) == dig(g, i)) common++;
    end
    c = common - b;
  endfunction

  function automatic logic [CW-1:0] rand_code();
    logic [CW-1:0] r;
    bit used [NV];
    int d;
    if ($urandom % 4 == 0) return CW'($urandom);
    for (int v = 0; v < NV; v++) used[v] = 1'b0;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      do d = int'($urandom_range(DMAX, 0)); while (used[d]);
      used[d] = 1'b1;
      r = r | (CW'(d) << (i * DW));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_turn = 0; m_win = 0; m_p1 = 0; m_p2 = 0;
    m_sec1 = '0; m_sec2 = '0;
`ifdef BULLCOW_ROUND_LIMIT_EN
    m_gc1 = 0; m_gc2 = 0;
`endif
  endtask

  task automatic push_exp(int kind, int at, int b, int c);
    exp_t e;
    e.kind = kind; e.at = at; e.bulls = b; e.cows = c;
    e.winner = m_win; e.p1 = m_p1; e.p2 = m_p2; e.st = m_st; e.turn = m_turn;
    q.push_back(e);
  endtask

  // Called at a negedge with the model in a ready state.
  task automatic do_enter(logic [CW-1:0] c);
    int t, b, cw;
    bit lim;
    chk("ready_before_enter", int'(bus.ready), 1);
    bus.code  = c;
    bus.enter = 1'b1;
    t = cyc;
    busy_until = t + 1;
    if (m_st == 7) begin
      m_st = 0; m_win = 0; m_turn = 0; m_sec1 = '0; m_sec2 = '0;
`ifdef BULLCOW_ROUND_LIMIT_EN
      m_gc1 = 0; m_gc2 = 0;
`endif
    end else if (!m_valid(c)) begin
      push_exp(0, t + 1, 0, 0);
    end else if (m_st == 0) begin
      m_sec1 = c; m_st = 1; m_turn = 1;
    end else if (m_st == 1) begin
      m_sec2 = c; m_st = 2; m_turn = 0;
    end else begin
      m_score(m_turn ? m_sec1 : m_sec2, c, b, cw);
      lim = 1'b0;
      if (b == NDIG) begin
        m_win = m_turn ? 2 : 1;
        if (m_turn) m_p2 = (m_p2 < PMAX) ? m_p2 + 1 : PMAX;
        else        m_p1 = (m_p1 < PMAX) ? m_p1 + 1 : PMAX;
        m_st = 7;
      end else begin
`ifdef BULLCOW_ROUND_LIMIT_EN
        if (m_turn) m_gc2++; else m_gc1++;
        lim = (m_turn == 1) && (m_gc1 == MAXG) && (m_gc2 == MAXG);
`endif
        if (lim) begin
          m_win = 3; m_st = 7;
        end else begin
          m_st = m_turn ? 2 : 3;
          m_turn = 1 - m_turn;
        end
      end
      push_exp(1, t + NDIG + 1, b, cw);
      busy_until = t + NDIG + 1;
    end
    @(negedge clock);
    bus.enter = 1'b0;
  endtask

  // Pulses enter without touching the model (ignored or aborted entries).
  task automatic raw_pulse(logic [CW-1:0] c, int exp_rdy);
    chk("ready_raw", int'(bus.ready), exp_rdy);
    bus.code  = c;
    bus.enter = 1'b1;
    @(negedge clock);
    bus.enter = 1'b0;
  endtask

  task automatic settle();
    while (cyc < busy_until) @(negedge clock);
    chk("state", int'(bus.state), m_st);
    chk("turn", int'(bus.turn), m_turn);
    chk("winner", int'(bus.winner), m_win);
    chk("points_p1", int'(bus.points_p1), m_p1);
    chk("points_p2", int'(bus.points_p2), m_p2);
    chk("ready", int'(bus.ready), 1);
  endtask

  task automatic enter_settle(logic [CW-1:0] c);
    do_enter(c);
    settle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_turn", int'(bus.turn), 0);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_result_valid", int'(bus.result_valid), 0);
    chk("rst_bulls", int'(bus.bulls), 0);
    chk("rst_cows", int'(bus.cows), 0);
    chk("rst_winner", int'(bus.winner), 0);
    chk("rst_points_p1", int'(bus.points_p1), 0);
    chk("rst_points_p2", int'(bus.points_p2), 0);
  endtask

  // Monitor: every err/result pulse must match the next expected entry.
  always @(negedge clock) begin
    if (!reset && (bus.err || bus.result_valid)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: err=%0d result_valid=%0d with nothing expected (cycle %0d)",
                 bus.err, bus.result_valid, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", int'(bus.result_valid), e.kind);
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_state", int'(bus.state), e.st);
        chk("pulse_turn", int'(bus.turn), e.turn);
        if (e.kind == 1) begin
          chk("bulls", int'(bus.bulls), e.bulls);
          chk("cows", int'(bus.cows), e.cows);
          chk("res_winner", int'(bus.winner), e.winner);
          chk("res_points_p1", int'(bus.points_p1), e.p1);
          chk("res_points_p2", int'(bus.points_p2), e.p2);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] rc;
    reset = 1'b1;
    bus.enter = 1'b0;
    bus.code  = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clock);

    // Invalid entries in SETUP1, then a full miss with 2 bulls / 2 cows
    enter_settle(16'h1123);
    enter_settle(16'h123A);
    chk("setup1_hold", int'(bus.state), 0);
    enter_settle(16'h1234);
    chk("setup2_state", int'(bus.state), 1);
    enter_settle(16'h5678);
    enter_settle(16'h5687);
    chk("dir_bulls", int'(bus.bulls), 2);
    chk("dir_cows", int'(bus.cows), 2);
    chk("dir_state", int'(bus.state), 3);
    chk("dir_turn", int'(bus.turn), 1);

    // enter during SCORE is ignored
    do_enter(16'h1243);
    raw_pulse(16'h1234, 0);
    settle();
    chk("ign_bulls", int'(bus.bulls), 2);
    chk("ign_state", int'(bus.state), 2);

    // P1 misses, P2 wins, END -> SETUP1 keeps points
    enter_settle(16'h8765);
    chk("rev_cows", int'(bus.cows), 4);
    enter_settle(16'h1234);
    chk("win_winner", int'(bus.winner), 2);
    chk("win_points_p2", int'(bus.points_p2), 1);
    chk("win_state", int'(bus.state), 7);
    enter_settle(16'h0000);
    chk("end_winner", int'(bus.winner), 0);
    chk("end_points_p2", int'(bus.points_p2), 1);
    chk("end_state", int'(bus.state), 0);

    // P1 wins four rounds: points saturate at 3
    for (int k = 0; k < 4; k++) begin
      enter_settle(16'h1234);
      enter_settle(16'h5678);
      enter_settle(16'h5678);
      chk("sat_points_p1", int'(bus.points_p1), (k + 1 > 3) ? 3 : k + 1);
      enter_settle(16'h0000);
    end

`ifdef BULLCOW_ROUND_LIMIT_EN
    enter_settle(16'h1234);
    enter_settle(16'h5678);
    for (int k = 0; k < 4; k++) enter_settle(16'h9012);
    chk("lim_winner", int'(bus.winner), 3);
    chk("lim_state", int'(bus.state), 7);
    enter_settle(16'h0000);
`endif

    // Random games
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 40 && m_st != 7; k++) begin
        rc = rand_code();
        if (m_st >= 2 && ($urandom % 5 == 0 || k == 39)) rc = m_turn ? m_sec1 : m_sec2;
        enter_settle(rc);
      end
      if (m_st == 7) enter_settle(rand_code());
    end

    // Reset in the middle of scoring aborts the result
    if (m_st != 0) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      @(negedge clock);
    end
    enter_settle(16'h1234);
    enter_settle(16'h5678);
    raw_pulse(16'h5678, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (NDIG + 3) @(negedge clock);
    chk("post_abort_state", int'(bus.state), 0);
    chk("pending_pulses", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
